// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller.
// MCTRL_ILLEGAL_TRAP_EN adds the TRAP state for illegal opcodes.
package mctrl_pkg;

    localparam int unsigned ST_W     = 4;
    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [ST_W-1:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JAL       = 4'd12
`ifdef MCTRL_ILLEGAL_TRAP_EN
        , TRAP    = 4'd13
`endif
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;

    localparam logic [1:0] ALUB_REGB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_JAL: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mctrl_output_decode.sv
// Moore output decode: state (plus opcode/mem_ready where needed) -> datapath controls.
// MCTRL_ILLEGAL_TRAP_EN selects trap vs. NOP handling of illegal opcodes.
module mctrl_output_decode
    import mctrl_pkg::*;
(
    input  state_t              i_state,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    output ctrl_t               o_ctrl_c
);

    always_comb begin
        o_ctrl_c = '0;
        case (i_state)
            FETCH: begin
                o_ctrl_c.mem_read  = 1'b1;
                o_ctrl_c.alu_src_b = ALUB_FOUR;
                o_ctrl_c.ir_write  = i_mem_ready;
                o_ctrl_c.pc_write  = i_mem_ready;
            end
            DECODE: begin
                o_ctrl_c.alu_src_b = ALUB_IMM_SH2;
`ifndef MCTRL_ILLEGAL_TRAP_EN
                // Illegal opcode retires here as a NOP
                o_ctrl_c.instr_done = !is_legal_op(i_opcode);
`endif
            end
            MEM_ADDR: begin
                o_ctrl_c.alu_src_a = 1'b1;
                o_ctrl_c.alu_src_b = ALUB_IMM;
            end
            MEM_READ: begin
                o_ctrl_c.mem_read = 1'b1;
                o_ctrl_c.iord     = 1'b1;
            end
            MEM_WB: begin
                o_ctrl_c.reg_dst    = RDST_RT;
                o_ctrl_c.mem_to_reg = M2R_MDR;
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                o_ctrl_c.mem_write  = 1'b1;
                o_ctrl_c.iord       = 1'b1;
                o_ctrl_c.instr_done = i_mem_ready;
            end
            R_EXEC: begin
                o_ctrl_c.alu_src_a = 1'b1;
                o_ctrl_c.alu_src_b = ALUB_REGB;
                o_ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                o_ctrl_c.reg_dst    = RDST_RD;
                o_ctrl_c.mem_to_reg = M2R_ALUOUT;
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.instr_done = 1'b1;
            end
            I_EXEC: begin
                o_ctrl_c.alu_src_a = 1'b1;
                o_ctrl_c.alu_src_b = ALUB_IMM;
                o_ctrl_c.alu_op    = imm_alu_op(i_opcode);
            end
            I_WB: begin
                o_ctrl_c.reg_dst    = RDST_RT;
                o_ctrl_c.mem_to_reg = M2R_ALUOUT;
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.instr_done = 1'b1;
            end
            BRANCH: begin
                o_ctrl_c.alu_src_a     = 1'b1;
                o_ctrl_c.alu_src_b     = ALUB_REGB;
                o_ctrl_c.alu_op        = ALUOP_SUB;
                o_ctrl_c.pc_write_cond = 1'b1;
                o_ctrl_c.pc_source     = PCSRC_ALUOUT;
                o_ctrl_c.instr_done    = 1'b1;
            end
            JAL: begin
                o_ctrl_c.pc_write   = 1'b1;
                o_ctrl_c.pc_source  = PCSRC_JUMP;
                o_ctrl_c.reg_dst    = RDST_RA;
                o_ctrl_c.mem_to_reg = M2R_PC;
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.instr_done = 1'b1;
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            TRAP: o_ctrl_c.trap = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: state register + dispatch, outputs decoded from state.
// MCTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP until reset instead of retiring as NOPs.
module multicycle_control_fsm
    import mctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemToReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               trap,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    ctrl_t  w_ctrl;

    // State register and next-state dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:      r_state <= FETCH;
                FETCH:     if (mem_ready) r_state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:              r_state <= MEM_ADDR;
                        OP_RTYPE:                  r_state <= R_EXEC;
                        OP_ADDI, OP_ANDI, OP_ORI:  r_state <= I_EXEC;
                        OP_BEQ:                    r_state <= BRANCH;
                        OP_JAL:                    r_state <= JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                        default:                   r_state <= TRAP;
`else
                        default:                   r_state <= FETCH;
`endif
                    endcase
                end
                MEM_ADDR:  r_state <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (mem_ready) r_state <= MEM_WB;
                MEM_WRITE: if (mem_ready) r_state <= FETCH;
                R_EXEC:    r_state <= R_WB;
                I_EXEC:    r_state <= I_WB;
                MEM_WB, R_WB, I_WB, BRANCH, JAL: r_state <= FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                TRAP:      r_state <= TRAP;
`endif
                default:   r_state <= IDLE;
            endcase
        end
    end

    mctrl_output_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl_c    (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemToReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign instr_done  = w_ctrl.instr_done;
    assign trap        = w_ctrl.trap;
    assign state       = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: random instruction stream with random memory stalls.
// Honours MCTRL_ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control_fsm;
    import mctrl_pkg::*;

    typedef logic [24:0] obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemToReg, RegDst, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, instr_done, trap;
    logic [2:0] ALUOp;
    logic [3:0] state;
    obs_t       w_obs;

    obs_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_exp  = 0;
    int   done_seen = 0;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    assign w_obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                    instr_done, trap};

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b001100, 6'b001101, 6'b000011};
    endfunction

    // Expected control word for one cycle, straight from the per-step control table
    function automatic obs_t model(input state_t s, input logic mr, input logic [5:0] op);
        logic       pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic       rw = 0, srca = 0, done = 0, trp = 0;
        logic [1:0] m2r = 0, rdst = 0, srcb = 0, pcsrc = 0;
        logic [2:0] aop = 0;
        case (s)
            FETCH:     begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
            DECODE:    begin
                srcb = 2'b11;
`ifndef MCTRL_ILLEGAL_TRAP_EN
                done = !legal(op);
`endif
            end
            MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
            MEM_READ:  begin mrd = 1; iord = 1; end
            MEM_WB:    begin m2r = 2'b01; rw = 1; done = 1; end
            MEM_WRITE: begin mwr = 1; iord = 1; done = mr; end
            R_EXEC:    begin srca = 1; aop = 3'b010; end
            R_WB:      begin rdst = 2'b01; rw = 1; done = 1; end
            I_EXEC:    begin
                srca = 1; srcb = 2'b10;
                aop = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b101 : 3'b000;
            end
            I_WB:      begin rw = 1; done = 1; end
            BRANCH:    begin srca = 1; aop = 3'b001; pcwc = 1; pcsrc = 2'b01; done = 1; end
            JAL:       begin pcw = 1; pcsrc = 2'b10; rdst = 2'b10; m2r = 2'b10; rw = 1; done = 1; end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            TRAP:      trp = 1;
`endif
            default: ;
        endcase
        return {4'(s), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb,
                aop, pcsrc, done, trp};
    endfunction

    // Monitor: every cycle with a queued expectation is compared at the falling edge
    always @(negedge clk) begin
        obs_t e;
        if (rst_n === 1'b1 && instr_done === 1'b1) done_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL cycle_ctrl t=%0t got=%h exp=%h", $time, w_obs, e);
            end
        end
    end

    task automatic direct_check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one cycle starting just after a rising edge and queue its expectation
    task automatic step(input state_t s, input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back(model(s, mr, op));
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(IDLE, 1'($urandom), 6'($urandom));
    endtask

    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        for (int i = 0; i < fstall; i++) step(FETCH, 1'b0, 6'($urandom));
        step(FETCH, 1'b1, 6'($urandom));
        step(DECODE, 1'($urandom), op);
        if (op == 6'b100011 || op == 6'b101011) begin
            step(MEM_ADDR, 1'($urandom), op);
            if (op == 6'b100011) begin
                for (int i = 0; i < mstall; i++) step(MEM_READ, 1'b0, op);
                step(MEM_READ, 1'b1, op);
                step(MEM_WB, 1'($urandom), op);
            end else begin
                for (int i = 0; i < mstall; i++) step(MEM_WRITE, 1'b0, op);
                step(MEM_WRITE, 1'b1, op);
            end
            done_exp++;
        end else if (op == 6'b000000) begin
            step(R_EXEC, 1'($urandom), op);
            step(R_WB, 1'($urandom), op);
            done_exp++;
        end else if (op inside {6'b001000, 6'b001100, 6'b001101}) begin
            step(I_EXEC, 1'($urandom), op);
            step(I_WB, 1'($urandom), op);
            done_exp++;
        end else if (op == 6'b000100) begin
            step(BRANCH, 1'($urandom), op);
            done_exp++;
        end else if (op == 6'b000011) begin
            step(JAL, 1'($urandom), op);
            done_exp++;
        end else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) step(TRAP, 1'($urandom), 6'($urandom));
            rst_n = 1'b0;
            #1;
            direct_check("trap_reset_clear", w_obs, '0);
            release_reset();
`else
            done_exp++;
`endif
        end
    endtask

    logic [5:0] ops [8];
    logic [5:0] op;

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b001100, 6'b001101, 6'b000011};
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        #12;
        direct_check("reset_idle", w_obs, '0);
        release_reset();

        run_instr(6'b100011, 0, 0);
        run_instr(6'b000000, 3, 0);
        run_instr(6'b001101, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000011, 0, 0);
        run_instr(6'b101011, 1, 2);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001100, 0, 0);

        // Abort a stalled store with an asynchronous reset
        run_instr(6'b101011, 0, 0);
        step(FETCH, 1'b1, 6'($urandom));
        step(DECODE, 1'b1, 6'b101011);
        step(MEM_ADDR, 1'b1, 6'b101011);
        mem_ready = 1'b0;
        #2;
        direct_check("mem_write_before_reset", w_obs, model(MEM_WRITE, 1'b0, 6'b101011));
        rst_n = 1'b0;
        #1;
        direct_check("mem_write_reset_abort", w_obs, '0);
        release_reset();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        checks++;
        if (done_seen != done_exp) begin
            failures++;
            $display("FAIL instr_done_count got=%0d exp=%0d", done_seen, done_exp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
